dmem_port_arbiter: RTL
======================

Name: dmem_port_arbiter

Overview:
- Shares the single 1R1W synchronous data memory (ccs_ram_sync_1R1W, 1-cycle read latency) among NREQ requesters, e.g. the scalar RISC core and the vector unit.
- The read port and the write port are arbitrated independently, each with its own round-robin pointer.
- Read data is routed back to the granted requester one cycle after the grant.
- Same-cycle read-after-write hazards to the same address are resolved by stalling the read.

Parameters:
- WIDTH, 32, data width in bits.
- ADDR_WIDTH, 15, word address width.
- NREQ, 2, number of requesters (2..8).

Ports:
- clk  in  1  clock; all logic is rising-edge.
- rst  in  1  asynchronous, active-low reset.
- req_vld  in  NREQ  request valid, one bit per requester.
- req_we  in  NREQ  1 = write request, 0 = read request.
- req_addr  in  NREQ*ADDR_WIDTH  word address; requester i occupies slice [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_wdata  in  NREQ*WIDTH  write data; requester i occupies slice [i*WIDTH +: WIDTH].
- req_rdy  out  NREQ  request accepted this cycle (grant).
- rsp_vld  out  NREQ  read data valid for requester i; one-cycle pulse; no backpressure.
- rsp_data  out  WIDTH  read data, shared bus, qualified by rsp_vld.
- mem_radr  out  ADDR_WIDTH  RAM read address.
- mem_re  out  1  RAM read enable.
- mem_wadr  out  ADDR_WIDTH  RAM write address.
- mem_we  out  1  RAM write enable.
- mem_d  out  WIDTH  RAM write data.
- mem_q  in  WIDTH  RAM read data, valid one cycle after mem_re.

Behaviour:
- Reset (rst=0, asynchronous):
  - req_rdy=0, rsp_vld=0, mem_re=0, mem_we=0; addresses and data outputs = 0.
  - rd_ptr=NREQ-1 and wr_ptr=NREQ-1, so requester 0 has first priority on both ports.
- Handshake:
  - A request transfers on req_vld[i] & req_rdy[i].
  - Requesters hold req_we, req_addr and req_wdata stable while req_vld is high and not yet granted.
- Write arbitration (combinational grant):
  - Among i with req_vld[i] & req_we[i], grant the first index after wr_ptr, searching cyclically.
  - On grant: mem_we=1, mem_wadr and mem_d = that requester's fields, same cycle.
  - wr_ptr updates to the granted index at the clock edge.
- Read arbitration: same scheme over req_vld[i] & ~req_we[i], using rd_ptr.
  - On grant: mem_re=1, mem_radr = that requester's address, same cycle.
- Hazard:
  - If a read and a write are both selected and their addresses are equal, the write proceeds and the read is not granted.
  - In that case mem_re=0, req_rdy stays 0 for the reader, and rd_ptr is unchanged.
  - The read is retried next cycle and returns the newly written data.
- Response path:
  - Registered owner tag plus valid bit.
  - Cycle after a read grant: rsp_vld[owner]=1 and rsp_data=mem_q, so read latency is exactly 1 cycle from the grant.
  - Back-to-back reads every cycle are supported at full throughput.
- Simultaneous events:
  - One read and one write from different requesters are both granted in the same cycle.
  - A requester issues at most one request per cycle, so it never holds both a read and a write grant.
- Idle: mem_re=0 and mem_we=0; rsp_vld=0 in the following cycle.
- Reset mid-operation: any in-flight read response is dropped and rsp_vld stays 0.
- Grants are never issued without req_vld. Arbitration is fair: with persistent requests, every requester is served within NREQ grants.

Optional Feature:
- Macro: DMEM_RAW_FWD_EN.
- Defined: on a same-address read/write collision, both are granted.
  - mem_re stays 0 for that cycle.
  - The write data is captured into a forward register.
  - Next cycle: rsp_vld[reader]=1 and rsp_data = forwarded write data instead of mem_q.
  - No stall; rd_ptr advances normally.
- Undefined: stall behaviour as specified in Behaviour.

Test Plan:
- Reset, then req_vld=2'b01 read addr 0x0010 with RAM[0x10]=0xDEADBEEF -> req_rdy=2'b01 same cycle, mem_re=1, mem_radr=0x0010; next cycle rsp_vld=2'b01, rsp_data=0xDEADBEEF.
- Both requesters read continuously for 4 cycles -> grants alternate 0,1,0,1; each rsp_vld follows one cycle later with the correct owner.
- Req0 writes 0x0020 <- 0x12345678 while req1 reads 0x0030 -> both req_rdy=1 in one cycle, mem_we=1 and mem_re=1.
- Req0 writes 0x0040 <- 0xCAFEF00D while req1 reads 0x0040:
  - Without macro: req1 stalls one cycle, then reads; rsp_data=0xCAFEF00D two cycles after first request.
  - With DMEM_RAW_FWD_EN: rsp_vld[1] next cycle with 0xCAFEF00D and mem_re=0.
- Read granted, then rst pulsed low before the next edge -> rsp_vld stays 0; after release, requester 0 has priority.
- No requests for 3 cycles -> mem_re=0, mem_we=0, rsp_vld=0 throughout.

Source files
------------

// File: rtl/dmem_port_arbiter.sv
// Round-robin arbiter sharing one 1R1W synchronous data RAM among NREQ requesters.
// Define DMEM_RAW_FWD_EN to forward write data on same-address read/write collisions instead of stalling the read.
module dmem_port_arbiter #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 15,
  parameter int NREQ       = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            req_vld,
  input  logic [NREQ-1:0]            req_we,
  input  logic [NREQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NREQ*WIDTH-1:0]      req_wdata,
  output logic [NREQ-1:0]            req_rdy,
  output logic [NREQ-1:0]            rsp_vld,
  output logic [WIDTH-1:0]           rsp_data,
  output logic [ADDR_WIDTH-1:0]      mem_radr,
  output logic                       mem_re,
  output logic [ADDR_WIDTH-1:0]      mem_wadr,
  output logic                       mem_we,
  output logic [WIDTH-1:0]           mem_d,
  input  logic [WIDTH-1:0]           mem_q
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  // Returns {found, index} of the first candidate strictly after ptr, wrapping around.
  function automatic logic [PW:0] rr_pick(input logic [NREQ-1:0] cand,
                                          input logic [PW-1:0]   ptr);
    logic          found;
    logic [PW-1:0] sel;
    int            idx;
    found = 1'b0;
    sel   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!found && cand[idx]) begin
        found = 1'b1;
        sel   = idx[PW-1:0];
      end
    end
    return {found, sel};
  endfunction

  logic [PW-1:0]         r_rd_ptr;
  logic [PW-1:0]         r_wr_ptr;
  logic                  r_rsp_vld;
  logic [PW-1:0]         r_rsp_owner;

  logic [NREQ-1:0]       w_rd_cand;
  logic [NREQ-1:0]       w_wr_cand;
  logic [PW:0]           w_rd_pick;
  logic [PW:0]           w_wr_pick;
  logic                  w_rd_found;
  logic                  w_wr_found;
  logic [PW-1:0]         w_rd_idx;
  logic [PW-1:0]         w_wr_idx;
  logic [ADDR_WIDTH-1:0] w_rd_addr;
  logic [ADDR_WIDTH-1:0] w_wr_addr;
  logic [WIDTH-1:0]      w_wr_data;
  logic                  w_hazard;
  logic                  w_rd_grant;
  logic                  w_rd_mem;
  logic                  w_wr_grant;

  assign w_rd_cand  = req_vld & ~req_we;
  assign w_wr_cand  = req_vld & req_we;
  assign w_rd_pick  = rr_pick(w_rd_cand, r_rd_ptr);
  assign w_wr_pick  = rr_pick(w_wr_cand, r_wr_ptr);
  assign w_rd_found = w_rd_pick[PW];
  assign w_wr_found = w_wr_pick[PW];
  assign w_rd_idx   = w_rd_pick[PW-1:0];
  assign w_wr_idx   = w_wr_pick[PW-1:0];

  assign w_rd_addr  = req_addr[w_rd_idx*ADDR_WIDTH +: ADDR_WIDTH];
  assign w_wr_addr  = req_addr[w_wr_idx*ADDR_WIDTH +: ADDR_WIDTH];
  assign w_wr_data  = req_wdata[w_wr_idx*WIDTH +: WIDTH];

  // Nothing is granted while reset is held, so the RAM and requesters see a quiet bus.
  assign w_hazard   = w_rd_found && w_wr_found && (w_rd_addr == w_wr_addr);
  assign w_wr_grant = rst && w_wr_found;
`ifdef DMEM_RAW_FWD_EN
  assign w_rd_grant = rst && w_rd_found;
  assign w_rd_mem   = w_rd_grant && !w_hazard;
`else
  assign w_rd_grant = rst && w_rd_found && !w_hazard;
  assign w_rd_mem   = w_rd_grant;
`endif

  always_comb begin
    req_rdy = '0;
    if (w_wr_grant) req_rdy[w_wr_idx] = 1'b1;
    if (w_rd_grant) req_rdy[w_rd_idx] = 1'b1;
  end

  assign mem_we   = w_wr_grant;
  assign mem_wadr = w_wr_grant ? w_wr_addr : '0;
  assign mem_d    = w_wr_grant ? w_wr_data : '0;
  assign mem_re   = w_rd_mem;
  assign mem_radr = w_rd_mem ? w_rd_addr : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_ptr    <= PW'(NREQ - 1);
      r_wr_ptr    <= PW'(NREQ - 1);
      r_rsp_vld   <= 1'b0;
      r_rsp_owner <= '0;
    end else begin
      if (w_wr_grant) r_wr_ptr <= w_wr_idx;
      if (w_rd_grant) begin
        r_rd_ptr    <= w_rd_idx;
        r_rsp_owner <= w_rd_idx;
      end
      r_rsp_vld <= w_rd_grant;
    end
  end

  always_comb begin
    rsp_vld = '0;
    if (r_rsp_vld) rsp_vld[r_rsp_owner] = 1'b1;
  end

`ifdef DMEM_RAW_FWD_EN
  logic             r_fwd_sel;
  logic [WIDTH-1:0] r_fwd_data;

  // A collided read takes its data from the write it raced, not from the RAM.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fwd_sel  <= 1'b0;
      r_fwd_data <= '0;
    end else begin
      r_fwd_sel <= w_rd_grant && w_hazard;
      if (w_rd_grant && w_hazard) r_fwd_data <= w_wr_data;
    end
  end

  assign rsp_data = !r_rsp_vld ? '0 : (r_fwd_sel ? r_fwd_data : mem_q);
`else
  assign rsp_data = r_rsp_vld ? mem_q : '0;
`endif

endmodule
